// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared MMU translation constants and result type
//
// Purpose: exception codes, DMW field positions and page-size encodings used by
// the data-side (and later fetch-side) address translators.
// Ports: none (package).
package mmu_pkg;

  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;

  localparam int DMW_PLV0    = 0;
  localparam int DMW_PLV3    = 3;
  localparam int DMW_MAT_LO  = 4;
  localparam int DMW_MAT_HI  = 5;
  localparam int DMW_PSEG_LO = 25;
  localparam int DMW_PSEG_HI = 27;
  localparam int DMW_VSEG_LO = 29;
  localparam int DMW_VSEG_HI = 31;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  typedef struct packed {
    logic [31:0] pa;
    logic [1:0]  mat;
    logic        excp;
    logic [5:0]  ecode;
    logic        use_tlb;
  } xlate_res_t;

endpackage

// File: rtl/mmu_xlate_core.sv
// rtl/mmu_xlate_core.sv - combinational VA->PA path selection and TLB checks
//
// Purpose: picks direct mode, DMW0, DMW1 or the TLB result for one VA and
// raises the TLB exceptions in priority order.
// Ports:
//   i_va, i_st                 virtual address, store flag
//   i_crmd_da/plv/datm         CRMD mode, privilege, direct-mode MAT
//   i_dmw0, i_dmw1             direct-mapped window CSRs
//   i_found/ppn/ps/plv/mat/d/v TLB search result
//   o_res                      {pa, mat, excp, ecode, use_tlb}
module mmu_xlate_core
  import mmu_pkg::*;
#(
  parameter bit HW_DIRTY = 1'b1
) (
  input  logic [31:0] i_va,
  input  logic        i_st,
  input  logic        i_crmd_da,
  input  logic [1:0]  i_crmd_plv,
  input  logic [1:0]  i_crmd_datm,
  input  logic [31:0] i_dmw0,
  input  logic [31:0] i_dmw1,
  input  logic        i_found,
  input  logic [19:0] i_ppn,
  input  logic [5:0]  i_ps,
  input  logic [1:0]  i_plv,
  input  logic [1:0]  i_mat,
  input  logic        i_d,
  input  logic        i_v,
  output xlate_res_t  o_res
);

  logic w_dmw0_hit;
  logic w_dmw1_hit;
  logic w_unused_dmw;

  // PLV-enable bits sit at the bit position equal to the privilege level.
  assign w_dmw0_hit = (i_va[31:29] == i_dmw0[DMW_VSEG_HI:DMW_VSEG_LO]) & i_dmw0[i_crmd_plv];
  assign w_dmw1_hit = (i_va[31:29] == i_dmw1[DMW_VSEG_HI:DMW_VSEG_LO]) & i_dmw1[i_crmd_plv];
  assign w_unused_dmw = ^{i_dmw0[28], i_dmw0[24:6], i_dmw1[28], i_dmw1[24:6]};

  always_comb begin
    o_res = '0;
    if (i_crmd_da) begin
      o_res.pa  = i_va;
      o_res.mat = i_crmd_datm;
    end else if (w_dmw0_hit) begin
      o_res.pa  = {i_dmw0[DMW_PSEG_HI:DMW_PSEG_LO], i_va[28:0]};
      o_res.mat = i_dmw0[DMW_MAT_HI:DMW_MAT_LO];
    end else if (w_dmw1_hit) begin
      o_res.pa  = {i_dmw1[DMW_PSEG_HI:DMW_PSEG_LO], i_va[28:0]};
      o_res.mat = i_dmw1[DMW_MAT_HI:DMW_MAT_LO];
    end else begin
      o_res.use_tlb = 1'b1;
      o_res.mat     = i_mat;
      if (i_ps == PS_4M) o_res.pa = {i_ppn[19:9], i_va[20:0]};
      else               o_res.pa = {i_ppn, i_va[11:0]};
      if (!i_found) begin
        o_res.excp  = 1'b1;
        o_res.ecode = ECODE_TLBR;
      end else if (!i_v) begin
        o_res.excp  = 1'b1;
        o_res.ecode = i_st ? ECODE_PIS : ECODE_PIL;
      end else if (i_crmd_plv > i_plv) begin
        o_res.excp  = 1'b1;
        o_res.ecode = ECODE_PPI;
      end else if (!HW_DIRTY && i_st && !i_d) begin
        o_res.excp  = 1'b1;
        o_res.ecode = ECODE_PME;
      end
    end
    // A faulting access must not leak a partial translation downstream.
    if (o_res.excp) begin
      o_res.pa  = '0;
      o_res.mat = '0;
    end
  end

endmodule

// File: rtl/mmu_data_xlate.sv
// rtl/mmu_data_xlate.sv - two-stage data address translator on TLB port 1
//
// Purpose: stage A drives TLB search port 1 from the held VA, stage B registers
// the translated response. INVTLB operands borrow port 1 and freeze stage A.
// Ports:
//   req_*    EX-stage request handshake (va, st)
//   resp_*   MEM-stage response handshake (pa, mat, excp, ecode, badv)
//   flush    kills both stages
//   crmd_*, dmw0/1, csr_asid   CSR inputs
//   inv_*    INVTLB operands
//   s1_* / st_inst / invtlb_*  TLB port 1
module mmu_data_xlate
  import mmu_pkg::*;
#(
  parameter bit HW_DIRTY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_va,
  input  logic        req_st,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_pa,
  output logic [1:0]  resp_mat,
  output logic        resp_excp,
  output logic [5:0]  resp_ecode,
  output logic [31:0] resp_badv,
  input  logic        flush,
  input  logic        crmd_da,
  input  logic        crmd_pg,
  input  logic [1:0]  crmd_plv,
  input  logic [1:0]  crmd_datm,
  input  logic [31:0] dmw0,
  input  logic [31:0] dmw1,
  input  logic [9:0]  csr_asid,
  input  logic        inv_req,
  input  logic [4:0]  inv_op,
  input  logic [9:0]  inv_asid,
  input  logic [31:0] inv_va,
  output logic [18:0] s1_vppn,
  output logic        s1_va_bit12,
  output logic [9:0]  s1_asid,
  output logic        st_inst,
  output logic        invtlb_valid,
  output logic [4:0]  invtlb_op,
  input  logic        s1_found,
  input  logic [3:0]  s1_index,
  input  logic [19:0] s1_ppn,
  input  logic [5:0]  s1_ps,
  input  logic [1:0]  s1_plv,
  input  logic [1:0]  s1_mat,
  input  logic        s1_d,
  input  logic        s1_v
);

  logic        r_a_valid;
  logic [31:0] r_a_va;
  logic        r_a_st;
  logic        r_b_valid;
  logic [31:0] r_b_pa;
  logic [1:0]  r_b_mat;
  logic        r_b_excp;
  logic [5:0]  r_b_ecode;
  logic [31:0] r_b_badv;

  logic        w_a_adv;
  logic        w_acc;
  logic        w_unused;
  xlate_res_t  w_res;

  assign w_unused = ^{s1_index, crmd_pg, inv_va[11:0]};

  assign w_a_adv   = r_a_valid & ~inv_req & ~flush & (~r_b_valid | resp_ready);
  assign req_ready = ~flush & (~r_a_valid | w_a_adv);
  assign w_acc     = req_valid & req_ready;

  // INVTLB borrows the search port for one cycle; stage A re-searches after.
  assign s1_vppn      = inv_req ? inv_va[31:13] : r_a_va[31:13];
  assign s1_va_bit12  = inv_req ? inv_va[12]    : r_a_va[12];
  assign s1_asid      = inv_req ? inv_asid      : csr_asid;
  assign invtlb_valid = inv_req;
  assign invtlb_op    = inv_op;

  mmu_xlate_core #(.HW_DIRTY(HW_DIRTY)) u_core (
    .i_va       (r_a_va),
    .i_st       (r_a_st),
    .i_crmd_da  (crmd_da),
    .i_crmd_plv (crmd_plv),
    .i_crmd_datm(crmd_datm),
    .i_dmw0     (dmw0),
    .i_dmw1     (dmw1),
    .i_found    (s1_found),
    .i_ppn      (s1_ppn),
    .i_ps       (s1_ps),
    .i_plv      (s1_plv),
    .i_mat      (s1_mat),
    .i_d        (s1_d),
    .i_v        (s1_v),
    .o_res      (w_res)
  );

  // The dirty mark fires only on the transfer edge, so a frozen or flushed
  // store never marks the page.
  assign st_inst = w_a_adv & r_a_st & w_res.use_tlb & ~w_res.excp & HW_DIRTY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_va    <= '0;
      r_a_st    <= 1'b0;
      r_b_valid <= 1'b0;
      r_b_pa    <= '0;
      r_b_mat   <= '0;
      r_b_excp  <= 1'b0;
      r_b_ecode <= '0;
      r_b_badv  <= '0;
    end else begin
      if (flush) begin
        r_a_valid <= 1'b0;
      end else if (w_acc) begin
        r_a_valid <= 1'b1;
        r_a_va    <= req_va;
        r_a_st    <= req_st;
      end else if (w_a_adv) begin
        r_a_valid <= 1'b0;
      end

      if (flush) begin
        r_b_valid <= 1'b0;
      end else if (w_a_adv) begin
        r_b_valid <= 1'b1;
        r_b_pa    <= w_res.pa;
        r_b_mat   <= w_res.mat;
        r_b_excp  <= w_res.excp;
        r_b_ecode <= w_res.ecode;
        r_b_badv  <= r_a_va;
      end else if (resp_ready) begin
        r_b_valid <= 1'b0;
      end
    end
  end

  assign resp_valid = r_b_valid;
  assign resp_pa    = r_b_pa;
  assign resp_mat   = r_b_mat;
  assign resp_excp  = r_b_excp;
  assign resp_ecode = r_b_ecode;
  assign resp_badv  = r_b_badv;

endmodule

// File: tb/tb_mmu_data_xlate.sv
// tb/tb_mmu_data_xlate.sv - directed vector bench for mmu_data_xlate
module tb_mmu_data_xlate;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_st, resp_ready, flush;
  logic [31:0] req_va;
  logic        crmd_da, crmd_pg;
  logic [1:0]  crmd_plv, crmd_datm;
  logic [31:0] dmw0, dmw1, inv_va;
  logic [9:0]  csr_asid, inv_asid;
  logic        inv_req;
  logic [4:0]  inv_op;
  logic        s1_found, s1_d, s1_v;
  logic [3:0]  s1_index;
  logic [19:0] s1_ppn;
  logic [5:0]  s1_ps;
  logic [1:0]  s1_plv, s1_mat;

  logic        req_ready1, resp_valid1, resp_excp1, st_inst1, invtlb_valid1, s1_va_bit12_1;
  logic [31:0] resp_pa1, resp_badv1;
  logic [1:0]  resp_mat1;
  logic [5:0]  resp_ecode1;
  logic [18:0] s1_vppn1;
  logic [9:0]  s1_asid1;
  logic [4:0]  invtlb_op1;

  logic        req_ready0, resp_valid0, resp_excp0, st_inst0, invtlb_valid0, s1_va_bit12_0;
  logic [31:0] resp_pa0, resp_badv0;
  logic [1:0]  resp_mat0;
  logic [5:0]  resp_ecode0;
  logic [18:0] s1_vppn0;
  logic [9:0]  s1_asid0;
  logic [4:0]  invtlb_op0;

  int total = 0;
  int bad   = 0;
  int st_cnt1 = 0;
  int st_cnt0 = 0;

  always #5 clk = ~clk;

  mmu_data_xlate #(.HW_DIRTY(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .req_va(req_va), .req_st(req_st),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_pa(resp_pa1), .resp_mat(resp_mat1),
    .resp_excp(resp_excp1), .resp_ecode(resp_ecode1), .resp_badv(resp_badv1), .flush(flush),
    .crmd_da(crmd_da), .crmd_pg(crmd_pg), .crmd_plv(crmd_plv), .crmd_datm(crmd_datm),
    .dmw0(dmw0), .dmw1(dmw1), .csr_asid(csr_asid), .inv_req(inv_req), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_va(inv_va), .s1_vppn(s1_vppn1), .s1_va_bit12(s1_va_bit12_1),
    .s1_asid(s1_asid1), .st_inst(st_inst1), .invtlb_valid(invtlb_valid1), .invtlb_op(invtlb_op1),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps), .s1_plv(s1_plv),
    .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v)
  );

  mmu_data_xlate #(.HW_DIRTY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0), .req_va(req_va), .req_st(req_st),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_pa(resp_pa0), .resp_mat(resp_mat0),
    .resp_excp(resp_excp0), .resp_ecode(resp_ecode0), .resp_badv(resp_badv0), .flush(flush),
    .crmd_da(crmd_da), .crmd_pg(crmd_pg), .crmd_plv(crmd_plv), .crmd_datm(crmd_datm),
    .dmw0(dmw0), .dmw1(dmw1), .csr_asid(csr_asid), .inv_req(inv_req), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_va(inv_va), .s1_vppn(s1_vppn0), .s1_va_bit12(s1_va_bit12_0),
    .s1_asid(s1_asid0), .st_inst(st_inst0), .invtlb_valid(invtlb_valid0), .invtlb_op(invtlb_op0),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps), .s1_plv(s1_plv),
    .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v)
  );

  always @(negedge clk) begin
    if (st_inst1) st_cnt1++;
    if (st_inst0) st_cnt0++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        da;
    logic [1:0]  datm;
    logic [1:0]  plv;
    logic [31:0] dmw0;
    logic [31:0] dmw1;
    logic [31:0] va;
    logic        st;
    logic        found;
    logic [5:0]  ps;
    logic [19:0] ppn;
    logic [1:0]  tplv;
    logic [1:0]  tmat;
    logic        d;
    logic        v;
    logic [31:0] pa1;
    logic [1:0]  mat1;
    logic [5:0]  ec1;
    logic        st1;
    logic [31:0] pa0;
    logic [5:0]  ec0;
  } vec_t;

  vec_t vecs[13];

  task automatic set_tlb(input logic found, input logic [5:0] ps, input logic [19:0] ppn,
                         input logic [1:0] tplv, input logic [1:0] tmat, input logic d, input logic v);
    s1_found = found; s1_ps = ps; s1_ppn = ppn; s1_plv = tplv; s1_mat = tmat; s1_d = d; s1_v = v;
  endtask

  initial begin : wdog
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int c1, c0, got, sent;
    logic acc, take, hold_flag;
    logic [31:0] hold_badv, hold_pa, exp_va;

    // da datm plv dmw0 dmw1 va st | found ps ppn tplv tmat d v | pa1 mat1 ec1 st1 | pa0 ec0
    vecs[0]  = '{1'b1, 2'd1, 2'd0, 32'h0, 32'h0, 32'h12345678, 1'b1, 1'b1, 6'd12, 20'h00080, 2'd0, 2'd2, 1'b1, 1'b1, 32'h12345678, 2'd1, 6'h00, 1'b0, 32'h12345678, 6'h00};
    vecs[1]  = '{1'b0, 2'd0, 2'd0, 32'h90000011, 32'h0, 32'h80001000, 1'b1, 1'b1, 6'd12, 20'h00080, 2'd0, 2'd2, 1'b1, 1'b1, 32'h00001000, 2'd1, 6'h00, 1'b0, 32'h00001000, 6'h00};
    vecs[2]  = '{1'b0, 2'd0, 2'd3, 32'h90000011, 32'h0, 32'h80001000, 1'b0, 1'b1, 6'd12, 20'h00080, 2'd3, 2'd2, 1'b1, 1'b1, 32'h00080000, 2'd2, 6'h00, 1'b0, 32'h00080000, 6'h00};
    vecs[3]  = '{1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h00403123, 1'b1, 1'b1, 6'd12, 20'h0ABCD, 2'd0, 2'd1, 1'b1, 1'b1, 32'h0ABCD123, 2'd1, 6'h00, 1'b1, 32'h0ABCD123, 6'h00};
    vecs[4]  = '{1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h00523456, 1'b0, 1'b1, 6'd21, 20'h0AB00, 2'd0, 2'd3, 1'b1, 1'b1, 32'h0AB23456, 2'd3, 6'h00, 1'b0, 32'h0AB23456, 6'h00};
    vecs[5]  = '{1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h00403123, 1'b1, 1'b0, 6'd12, 20'h0ABCD, 2'd0, 2'd1, 1'b1, 1'b1, 32'h0, 2'd0, 6'h3F, 1'b0, 32'h0, 6'h3F};
    vecs[6]  = '{1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h00403123, 1'b1, 1'b1, 6'd12, 20'h0ABCD, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 2'd0, 6'h02, 1'b0, 32'h0, 6'h02};
    vecs[7]  = '{1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h00403123, 1'b0, 1'b1, 6'd12, 20'h0ABCD, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 2'd0, 6'h01, 1'b0, 32'h0, 6'h01};
    vecs[8]  = '{1'b0, 2'd0, 2'd3, 32'h0, 32'h0, 32'h00403123, 1'b0, 1'b1, 6'd12, 20'h0ABCD, 2'd0, 2'd1, 1'b1, 1'b1, 32'h0, 2'd0, 6'h07, 1'b0, 32'h0, 6'h07};
    vecs[9]  = '{1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h00403123, 1'b1, 1'b1, 6'd12, 20'h0ABCD, 2'd0, 2'd1, 1'b0, 1'b1, 32'h0ABCD123, 2'd1, 6'h00, 1'b1, 32'h0, 6'h04};
    vecs[10] = '{1'b0, 2'd0, 2'd0, 32'hA2000011, 32'hA4000029, 32'hA0000123, 1'b0, 1'b0, 6'd12, 20'h0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h20000123, 2'd1, 6'h00, 1'b0, 32'h20000123, 6'h00};
    vecs[11] = '{1'b0, 2'd0, 2'd3, 32'hA2000011, 32'hA4000029, 32'hA0000123, 1'b0, 1'b0, 6'd12, 20'h0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h40000123, 2'd2, 6'h00, 1'b0, 32'h40000123, 6'h00};
    vecs[12] = '{1'b0, 2'd0, 2'd3, 32'h0, 32'h0, 32'h00403123, 1'b0, 1'b1, 6'd12, 20'h0ABCD, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 2'd0, 6'h01, 1'b0, 32'h0, 6'h01};

    rst = 1'b1; req_valid = 0; req_va = 0; req_st = 0; resp_ready = 0; flush = 0;
    crmd_da = 0; crmd_pg = 1; crmd_plv = 0; crmd_datm = 0; dmw0 = 0; dmw1 = 0;
    csr_asid = 10'h2A; inv_req = 0; inv_op = 0; inv_asid = 0; inv_va = 0; s1_index = 0;
    set_tlb(0, 6'd12, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid1}, 0);
    chk("rst_resp_pa", resp_pa1, 0);
    chk("rst_resp_badv", resp_badv1, 0);
    chk("rst_resp_ecode", {26'b0, resp_ecode1}, 0);
    chk("rst_st_inst", {31'b0, st_inst1}, 0);
    chk("rst_invtlb_valid", {31'b0, invtlb_valid1}, 0);
    chk("rst_s1_vppn", {13'b0, s1_vppn1}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Vector table: one isolated request each, latency checked
    foreach (vecs[i]) begin
      crmd_da = vecs[i].da; crmd_pg = ~vecs[i].da; crmd_datm = vecs[i].datm; crmd_plv = vecs[i].plv;
      dmw0 = vecs[i].dmw0; dmw1 = vecs[i].dmw1;
      set_tlb(vecs[i].found, vecs[i].ps, vecs[i].ppn, vecs[i].tplv, vecs[i].tmat, vecs[i].d, vecs[i].v);
      req_valid = 1; req_va = vecs[i].va; req_st = vecs[i].st; resp_ready = 1;
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", i), {31'b0, req_ready1}, 1);
      c1 = st_cnt1; c0 = st_cnt0;
      @(posedge clk); #1 req_valid = 0;
      @(negedge clk);
      chk($sformatf("v%0d_lat_n1", i), {31'b0, resp_valid1}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'b0, resp_valid1}, 1);
      chk($sformatf("v%0d_pa", i), resp_pa1, vecs[i].pa1);
      chk($sformatf("v%0d_mat", i), {30'b0, resp_mat1}, {30'b0, vecs[i].mat1});
      chk($sformatf("v%0d_excp", i), {31'b0, resp_excp1}, {31'b0, vecs[i].ec1 != 6'h0});
      chk($sformatf("v%0d_ecode", i), {26'b0, resp_ecode1}, {26'b0, vecs[i].ec1});
      chk($sformatf("v%0d_badv", i), resp_badv1, vecs[i].va);
      chk($sformatf("v%0d_st_cnt", i), st_cnt1 - c1, {31'b0, vecs[i].st1});
      chk($sformatf("v%0d_hd0_pa", i), resp_pa0, vecs[i].pa0);
      chk($sformatf("v%0d_hd0_mat", i), {30'b0, resp_mat0}, (vecs[i].ec0 != 6'h0) ? 32'h0 : {30'b0, vecs[i].mat1});
      chk($sformatf("v%0d_hd0_ecode", i), {26'b0, resp_ecode0}, {26'b0, vecs[i].ec0});
      chk($sformatf("v%0d_hd0_st_cnt", i), st_cnt0 - c0, 0);
      @(posedge clk); #1;
    end

    // Backpressure: ten requests, resp_ready toggling, odd ones are stores
    crmd_da = 0; crmd_plv = 0; dmw0 = 0; dmw1 = 0;
    set_tlb(1, 6'd12, 20'h0ABCD, 0, 1, 1, 1);
    c1 = st_cnt1; got = 0; sent = 0; hold_flag = 0;
    for (int cyc = 0; cyc < 120 && got < 10; cyc++) begin
      resp_ready = cyc[0];
      req_valid = (sent < 10);
      req_va = 32'h00400000 | (sent << 4);
      req_st = sent[0];
      @(negedge clk);
      if (hold_flag) chk("bp_hold_badv", resp_badv1, hold_badv);
      if (hold_flag) chk("bp_hold_pa", resp_pa1, hold_pa);
      hold_flag = resp_valid1 & ~resp_ready;
      hold_badv = resp_badv1; hold_pa = resp_pa1;
      acc = req_valid & req_ready1;
      take = resp_valid1 & resp_ready;
      if (take) begin
        exp_va = 32'h00400000 | (got << 4);
        chk($sformatf("bp_badv%0d", got), resp_badv1, exp_va);
        chk($sformatf("bp_pa%0d", got), resp_pa1, {20'h0ABCD, exp_va[11:0]});
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    req_valid = 0; resp_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("bp_got", got, 10);
    chk("bp_no_dup", {31'b0, resp_valid1}, 0);
    chk("bp_st_cnt", st_cnt1 - c1, 5);
    @(posedge clk); #1;

    // INVTLB collides with a store held in stage A
    req_valid = 1; req_va = 32'h00403123; req_st = 1;
    @(posedge clk); #1;
    req_valid = 0; inv_req = 1; inv_op = 5'd5; inv_asid = 10'h155; inv_va = 32'hDEADB000;
    @(negedge clk);
    chk("inv_vppn", {13'b0, s1_vppn1}, {13'b0, inv_va[31:13]});
    chk("inv_bit12", {31'b0, s1_va_bit12_1}, {31'b0, inv_va[12]});
    chk("inv_asid", {22'b0, s1_asid1}, 32'h155);
    chk("inv_valid", {31'b0, invtlb_valid1}, 1);
    chk("inv_op", {27'b0, invtlb_op1}, 5);
    chk("inv_no_st", {31'b0, st_inst1}, 0);
    chk("inv_req_ready", {31'b0, req_ready1}, 0);
    @(posedge clk); #1 inv_req = 0;
    @(negedge clk);
    chk("inv_no_adv", {31'b0, resp_valid1}, 0);
    chk("inv_research_vppn", {13'b0, s1_vppn1}, 32'h00403123 >> 13);
    chk("inv_st_after", {31'b0, st_inst1}, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("inv_resp_valid", {31'b0, resp_valid1}, 1);
    chk("inv_resp_pa", resp_pa1, 32'h0ABCD123);
    @(posedge clk); #1;

    // Same collision, but flush (with another INVTLB) lands in the next cycle
    c1 = st_cnt1;
    req_valid = 1; req_va = 32'h00403123; req_st = 1;
    @(posedge clk); #1;
    req_valid = 0; inv_req = 1;
    @(posedge clk); #1;
    flush = 1; req_valid = 1;
    @(negedge clk);
    chk("fl_no_st", {31'b0, st_inst1}, 0);
    chk("fl_req_ready", {31'b0, req_ready1}, 0);
    chk("fl_inv_fwd", {31'b0, invtlb_valid1}, 1);
    @(posedge clk); #1 flush = 0; inv_req = 0; req_valid = 0;
    @(negedge clk);
    chk("fl_resp_valid0", {31'b0, resp_valid1}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl_resp_valid1", {31'b0, resp_valid1}, 0);
    chk("fl_st_cnt", st_cnt1 - c1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmu_data_xlate.md
# mmu_data_xlate

Two-stage pipelined data-address translator between the EX-stage load/store request and the MEM-stage cache request. It owns `tlb` search port 1, applying direct mode, two direct-mapped windows (DMW0/1) or page-table translation. It produces a physical address, MAT and exception code per request. It also multiplexes INVTLB operands onto port 1 and drives the store-dirty mark.

## Interface

Parameters:

- `HW_DIRTY`, 1, 1: stores set the D bit through `tlb_st_inst` and never raise PME. 0: a store to a page with D=0 raises PME and no mark is issued.

Ports:

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid` / `req_ready`  in/out  1  request handshake
- `req_va`  in  32  virtual address
- `req_st`  in  1  1 = store
- `resp_valid` / `resp_ready`  out/in  1  response handshake
- `resp_pa`  out  32  physical address
- `resp_mat`  out  2  memory access type
- `resp_excp`  out  1  translation exception
- `resp_ecode`  out  6  exception code
- `resp_badv`  out  32  VA of the response
- `flush`  in  1  kill all in-flight requests
- `crmd_da`, `crmd_pg`  in  1  CSR.CRMD mode bits
- `crmd_plv`  in  2  current privilege level
- `crmd_datm`  in  2  MAT in direct mode
- `dmw0`, `dmw1`  in  32  CSR.DMW0/1
- `csr_asid`  in  10  CSR.ASID.ASID
- `inv_req`  in  1  INVTLB pulse, always accepted
- `inv_op`  in  5  INVTLB op
- `inv_asid`  in  10  INVTLB ASID operand
- `inv_va`  in  32  INVTLB VA operand
- `s1_vppn`, `s1_va_bit12`, `s1_asid`, `st_inst`, `invtlb_valid`, `invtlb_op`  out  to `tlb` port 1
- `s1_found`, `s1_index`, `s1_ppn`, `s1_ps`, `s1_plv`, `s1_mat`, `s1_d`, `s1_v`  in  from `tlb` port 1

## Operation

- **Stage A register.** Holds `a_valid`, `a_va` and `a_st`. Port 1 is driven from it: `s1_vppn = a_va[31:13]`, `s1_va_bit12 = a_va[12]`, `s1_asid = csr_asid`.
- **INVTLB cycles.** When `inv_req=1`:
  - port 1 carries `inv_va` and `inv_asid` instead;
  - `invtlb_valid=1` and `invtlb_op=inv_op`;
  - stage A is frozen and does not advance.
- **Translation path selection**, in priority order:
  - `crmd_da=1`: PA = VA, MAT = `crmd_datm`.
  - DMWn hit: `va[31:29]==dmwn[31:29]` and the PLV-enable bit `dmwn[crmd_plv]` is set (only bits 0 and 3 are meaningful). PA = {`dmwn[27:25]`, `va[28:0]`}, MAT = `dmwn[5:4]`. DMW0 wins over DMW1.
  - Otherwise TLB. With `s1_ps==12`, PA = {`ppn`, `va[11:0]`}. With `s1_ps==21`, PA = {`ppn[19:9]`, `va[20:0]`}. MAT = `s1_mat`.
- **TLB exceptions**, first match wins:
  - `!s1_found` → TLBR (0x3F);
  - `!s1_v` → PIL (0x1) for a load, PIS (0x2) for a store;
  - `crmd_plv > s1_plv` → PPI (0x7);
  - `HW_DIRTY=0`, store and `!s1_d` → PME (0x4).
- **Exception response.** When an exception is raised, `resp_pa` = 0 and `resp_mat` = 0.
- **Store mark.** `st_inst=1` only in the cycle stage A transfers to stage B, when all of these hold:
  - `a_st` is set;
  - the TLB path is taken with no exception;
  - `HW_DIRTY=1`;
  - `!flush` and `!inv_req`.
- **Stage B.** Registered response holding the PA, MAT, exception and badv fields.

## Timing

- **Reset values.** All valids 0, every `resp_*` output 0, `a_va` 0. `st_inst` and `invtlb_valid` are 0.
- **Latency.** A request accepted at edge N is in stage A during cycle N+1 and gives `resp_valid=1` from cycle N+2.
- **Throughput.** One request per cycle when `resp_ready` stays high.
- **Advance and ready.**
  - `a_adv = a_valid & !inv_req & !flush & (!b_valid | resp_ready)`.
  - `req_ready = !flush & (!a_valid | a_adv)`.
  - `req_ready` must not depend on `req_valid`.
- **Output stability.** `resp_*` is held stable while `resp_valid & !resp_ready`.
- **Flush.** Both valids clear at the next edge, and nothing is accepted in the flush cycle. An `inv_req` in the same cycle is still forwarded to the TLB.
- **INVTLB during backpressure.** No effect on stage B. Stage A re-searches in the next non-INVTLB cycle.
- **CSR inputs** are sampled combinationally during the stage-A cycle. A CSR change applies to whatever occupies stage A.
- **Reset mid-operation.** Everything is dropped immediately and asynchronously.

## Structure

- **`mmu_pkg`** holds the shared definitions:
  - ecode constants TLBR, PIL, PIS, PME, PPI;
  - DMW field bit positions (PLV0=0, PLV3=3, MAT 5:4, PSEG 27:25, VSEG 31:29);
  - PS constants 12 and 21.
- **`mmu_xlate_core`** is one combinational sub-module. It takes the VA, CSRs and TLB result and returns {pa, mat, excp, ecode, use_tlb}. It is later shared with the fetch-side translator. The top level contains the stage registers, handshakes and port-1 mux.

## Test plan

- **Direct mode.** `crmd_da=1`, `crmd_datm=1`, VA 0x1234_5678 → PA 0x1234_5678, MAT 1, no exception, valid two cycles after accept.
- **DMW hit and miss.** `dmw0=0x9000_0011`, PLV0, VA 0x8000_1000 → PA 0x0000_1000, MAT 1. The same request at PLV3 misses the window and takes the TLB path.
- **TLB 4KB and 4MB.**
  - 4KB page, `ppn=0x0ABCD`, VA 0x0040_3123 → PA 0x0ABC_D123.
  - 4MB page, `ppn=0x0AB00`, VA 0x0052_3456 → PA 0x0AB2_3456.
- **Exception priority.**
  - Miss → ecode 0x3F.
  - `v=0` store → 0x2.
  - PLV3 access to a `plv=0` page → 0x7.
  - `HW_DIRTY=0`, store with `d=0` → 0x4.
  - `HW_DIRTY=1`, same store → no exception and exactly one `st_inst` pulse.
- **Backpressure and throughput.** Ten back-to-back requests with `resp_ready` toggling 1/0 → all ten responses in order, none dropped or duplicated, and `st_inst` pulses once per store.
- **INVTLB and flush collision.** `inv_req` with op 5 while stage A holds a store:
  - port 1 shows the `inv_va` fields that cycle;
  - no `st_inst` and no advance that cycle;
  - the store completes on the next cycle.
  - `flush` in that next cycle instead → no response, no `st_inst`.
